// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, ALU-op and immediate-format encodings, ID/EX bundle.
// Option macro DECODE_REGFILE_BYPASS_EN selects write-to-read bypass in register_file.
package decode_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_NONE = 2'b00,
        IMM_I    = 2'b01,
        IMM_S    = 2'b10,
        IMM_B    = 2'b11
    } imm_fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        alu_op_e           alu_op;
    } id_ex_t;

    function automatic logic [XLEN-1:0] gen_imm(
        input imm_fmt_e    fmt,
        input logic [31:0] ins
    );
        logic [XLEN-1:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7],
                            ins[30:25], ins[11:8], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/register_file.sv
// register_file: 32x32 integer registers, two combinational reads, one write.
// DECODE_REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module register_file
    import decode_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Next register contents; x0 is never written so it stays zero
    always_comb begin
        regs_d = regs_q;
        if (we && waddr != '0) begin
            regs_d[waddr] = wdata;
        end
    end

    // Register array storage, cleared by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef DECODE_REGFILE_BYPASS_EN
    assign rdata1 = (raddr1 == '0) ? '0 :
                    (we && waddr == raddr1) ? wdata : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 :
                    (we && waddr == raddr2) ? wdata : regs_q[raddr2];
`else
    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
`endif

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode, hazard detection, branch resolve, ID/EX register.
// DECODE_REGFILE_BYPASS_EN removes the write-back stall by bypassing in the regfile.
module decode_stage
    import decode_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_if_id,
    input  logic [31:0] instr_if_id,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    output logic        load_pc,
    output logic        load_if_id_register,
    output logic        mux_sel,
    output logic [31:0] pc_branch_value,
    output logic [31:0] id_ex_pc,
    output logic [31:0] id_ex_rs1_data,
    output logic [31:0] id_ex_rs2_data,
    output logic [31:0] id_ex_imm,
    output logic [4:0]  id_ex_rs1,
    output logic [4:0]  id_ex_rs2,
    output logic [4:0]  id_ex_rd,
    output logic [2:0]  id_ex_funct3,
    output logic        id_ex_funct7b5,
    output logic        id_ex_reg_write,
    output logic        id_ex_mem_read,
    output logic        id_ex_mem_write,
    output logic        id_ex_mem_to_reg,
    output logic        id_ex_alu_src,
    output logic [1:0]  id_ex_alu_op
);

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;

    assign opcode = instr_if_id[6:0];
    assign rd     = instr_if_id[11:7];
    assign funct3 = instr_if_id[14:12];
    assign rs1    = instr_if_id[19:15];
    assign rs2    = instr_if_id[24:20];

    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    register_file u_rf (
        .clock  (clock),
        .reset  (reset),
        .we     (wb_reg_write),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    logic is_r;
    logic is_i;
    logic is_lw;
    logic is_sw;
    logic is_br;

    assign is_r  = opcode == OP_R;
    assign is_i  = opcode == OP_I;
    assign is_lw = opcode == OP_LW;
    assign is_sw = opcode == OP_SW;
    assign is_br = opcode == OP_BR &&
                   (funct3 == F3_BEQ || funct3 == F3_BNE);

    logic     dec_valid;
    logic     dec_branch;
    logic     use_rs1;
    logic     use_rs2;
    logic     dec_rw;
    logic     dec_mr;
    logic     dec_mw;
    logic     dec_m2r;
    logic     dec_as;
    alu_op_e  dec_alu_op;
    imm_fmt_e dec_fmt;

    // Control decode; unsupported encodings leave everything at zero
    always_comb begin
        dec_valid  = 1'b0;
        dec_branch = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        dec_rw     = 1'b0;
        dec_mr     = 1'b0;
        dec_mw     = 1'b0;
        dec_m2r    = 1'b0;
        dec_as     = 1'b0;
        dec_alu_op = ALU_ADD;
        dec_fmt    = IMM_NONE;
        unique case (1'b1)
            is_r: begin
                dec_valid  = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec_rw     = 1'b1;
                dec_alu_op = ALU_FUNCT;
            end
            is_i: begin
                dec_valid  = 1'b1;
                use_rs1    = 1'b1;
                dec_rw     = 1'b1;
                dec_as     = 1'b1;
                dec_alu_op = ALU_FUNCT;
                dec_fmt    = IMM_I;
            end
            is_lw: begin
                dec_valid = 1'b1;
                use_rs1   = 1'b1;
                dec_rw    = 1'b1;
                dec_mr    = 1'b1;
                dec_m2r   = 1'b1;
                dec_as    = 1'b1;
                dec_fmt   = IMM_I;
            end
            is_sw: begin
                dec_valid = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                dec_mw    = 1'b1;
                dec_as    = 1'b1;
                dec_fmt   = IMM_S;
            end
            is_br: begin
                dec_valid  = 1'b1;
                dec_branch = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec_alu_op = ALU_SUB;
                dec_fmt    = IMM_B;
            end
            default: ;
        endcase
    end

    id_ex_t id_ex_q;
    id_ex_t id_ex_d;
    logic   squash_q;
    logic   squash_d;

    logic rs1_live;
    logic rs2_live;
    logic load_use;
    logic br_hz;
    logic wb_hz;
    logic stall;
    logic taken;

    assign rs1_live = use_rs1 && rs1 != '0;
    assign rs2_live = use_rs2 && rs2 != '0;

    // Hazard detection and branch resolution; squash outranks stall
    always_comb begin
        load_use = id_ex_q.mem_read && id_ex_q.rd != '0 &&
                   ((use_rs1 && rs1 == id_ex_q.rd) ||
                    (use_rs2 && rs2 == id_ex_q.rd));
        br_hz = dec_branch &&
                ((rs1_live && id_ex_q.reg_write && rs1 == id_ex_q.rd) ||
                 (rs2_live && id_ex_q.reg_write && rs2 == id_ex_q.rd) ||
                 (rs1_live && mem_reg_write && rs1 == mem_rd) ||
                 (rs2_live && mem_reg_write && rs2 == mem_rd));
`ifdef DECODE_REGFILE_BYPASS_EN
        wb_hz = 1'b0;
`else
        wb_hz = wb_reg_write &&
                ((rs1_live && rs1 == wb_rd) ||
                 (rs2_live && rs2 == wb_rd));
`endif
        stall = reset && !squash_q && (load_use || br_hz || wb_hz);
        taken = reset && !squash_q && !stall && dec_branch &&
                ((funct3 == F3_BEQ) ? (rs1_data == rs2_data)
                                    : (rs1_data != rs2_data));
    end

    assign load_pc             = !stall;
    assign load_if_id_register = !stall;
    assign mux_sel             = taken;
    assign pc_branch_value     = pc_if_id - 32'd4 +
                                 gen_imm(IMM_B, instr_if_id);

    // Next ID/EX contents; squash, stall or bad opcode insert a bubble
    always_comb begin
        id_ex_d  = '0;
        squash_d = taken;
        if (!squash_q && !stall && dec_valid) begin
            id_ex_d.pc         = pc_if_id;
            id_ex_d.rs1_data   = rs1_data;
            id_ex_d.rs2_data   = rs2_data;
            id_ex_d.imm        = gen_imm(dec_fmt, instr_if_id);
            id_ex_d.rs1        = rs1;
            id_ex_d.rs2        = rs2;
            id_ex_d.rd         = dec_rw ? rd : '0;
            id_ex_d.funct3     = funct3;
            id_ex_d.funct7b5   = instr_if_id[30];
            id_ex_d.reg_write  = dec_rw;
            id_ex_d.mem_read   = dec_mr;
            id_ex_d.mem_write  = dec_mw;
            id_ex_d.mem_to_reg = dec_m2r;
            id_ex_d.alu_src    = dec_as;
            id_ex_d.alu_op     = dec_alu_op;
        end
    end

    // ID/EX pipeline register and squash flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            id_ex_q  <= '0;
            squash_q <= 1'b0;
        end else begin
            id_ex_q  <= id_ex_d;
            squash_q <= squash_d;
        end
    end

    assign id_ex_pc         = id_ex_q.pc;
    assign id_ex_rs1_data   = id_ex_q.rs1_data;
    assign id_ex_rs2_data   = id_ex_q.rs2_data;
    assign id_ex_imm        = id_ex_q.imm;
    assign id_ex_rs1        = id_ex_q.rs1;
    assign id_ex_rs2        = id_ex_q.rs2;
    assign id_ex_rd         = id_ex_q.rd;
    assign id_ex_funct3     = id_ex_q.funct3;
    assign id_ex_funct7b5   = id_ex_q.funct7b5;
    assign id_ex_reg_write  = id_ex_q.reg_write;
    assign id_ex_mem_read   = id_ex_q.mem_read;
    assign id_ex_mem_write  = id_ex_q.mem_write;
    assign id_ex_mem_to_reg = id_ex_q.mem_to_reg;
    assign id_ex_alu_src    = id_ex_q.alu_src;
    assign id_ex_alu_op     = id_ex_q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors, an instruction-level reference model
// checked every cycle, and literal expectations for the key scenarios.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_if_id;
    logic [31:0] instr_if_id;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic        load_pc;
    logic        load_if_id_register;
    logic        mux_sel;
    logic [31:0] pc_branch_value;
    logic [31:0] id_ex_pc;
    logic [31:0] id_ex_rs1_data;
    logic [31:0] id_ex_rs2_data;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rs1;
    logic [4:0]  id_ex_rs2;
    logic [4:0]  id_ex_rd;
    logic [2:0]  id_ex_funct3;
    logic        id_ex_funct7b5;
    logic        id_ex_reg_write;
    logic        id_ex_mem_read;
    logic        id_ex_mem_write;
    logic        id_ex_mem_to_reg;
    logic        id_ex_alu_src;
    logic [1:0]  id_ex_alu_op;

    decode_stage dut (
        .clock               (clock),
        .reset               (reset),
        .pc_if_id            (pc_if_id),
        .instr_if_id         (instr_if_id),
        .wb_reg_write        (wb_reg_write),
        .wb_rd               (wb_rd),
        .wb_data             (wb_data),
        .mem_reg_write       (mem_reg_write),
        .mem_rd              (mem_rd),
        .load_pc             (load_pc),
        .load_if_id_register (load_if_id_register),
        .mux_sel             (mux_sel),
        .pc_branch_value     (pc_branch_value),
        .id_ex_pc            (id_ex_pc),
        .id_ex_rs1_data      (id_ex_rs1_data),
        .id_ex_rs2_data      (id_ex_rs2_data),
        .id_ex_imm           (id_ex_imm),
        .id_ex_rs1           (id_ex_rs1),
        .id_ex_rs2           (id_ex_rs2),
        .id_ex_rd            (id_ex_rd),
        .id_ex_funct3        (id_ex_funct3),
        .id_ex_funct7b5      (id_ex_funct7b5),
        .id_ex_reg_write     (id_ex_reg_write),
        .id_ex_mem_read      (id_ex_mem_read),
        .id_ex_mem_write     (id_ex_mem_write),
        .id_ex_mem_to_reg    (id_ex_mem_to_reg),
        .id_ex_alu_src       (id_ex_alu_src),
        .id_ex_alu_op        (id_ex_alu_op)
    );

    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;
    logic run = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        as;
        logic [1:0]  op;
    } mex_t;

    typedef struct packed {
        logic        load;
        logic        tk;
        logic [31:0] tgt;
        mex_t        nx;
    } exp_t;

    logic [31:0] mregs [32];
    mex_t        m_ex;
    logic        m_sq;
    exp_t        cmp_e;
    exp_t        upd_e;

    function automatic logic [31:0] rdv(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef DECODE_REGFILE_BYPASS_EN
        if (wb_reg_write && wb_rd == a) return wb_data;
`endif
        return mregs[a];
    endfunction

    // Instruction-level view: classify, read, decide stall/branch, build ID/EX
    function automatic exp_t model_eval();
        exp_t e;
        int kind;
        int hi;
        int bb;
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] rd;
        logic [2:0] f3;
        logic [31:0] v1;
        logic [31:0] v2;
        logic u1;
        logic u2;
        logic hz;
        a1 = instr_if_id[19:15];
        a2 = instr_if_id[24:20];
        rd = instr_if_id[11:7];
        f3 = instr_if_id[14:12];
        kind = 0;
        case (instr_if_id[6:0])
            7'h33: kind = 1;
            7'h13: kind = 2;
            7'h03: kind = 3;
            7'h23: kind = 4;
            7'h63: kind = (f3 < 3'd2) ? 5 : 0;
            default: kind = 0;
        endcase
        v1 = rdv(a1);
        v2 = rdv(a2);
        u1 = kind != 0;
        u2 = kind == 1 || kind == 4 || kind == 5;
        hz = 1'b0;
        if (m_ex.mr && m_ex.rd != 0 &&
            ((u1 && a1 == m_ex.rd) || (u2 && a2 == m_ex.rd))) hz = 1'b1;
        if (kind == 5) begin
            if (a1 != 0 && ((m_ex.rw && a1 == m_ex.rd) ||
                            (mem_reg_write && a1 == mem_rd))) hz = 1'b1;
            if (a2 != 0 && ((m_ex.rw && a2 == m_ex.rd) ||
                            (mem_reg_write && a2 == mem_rd))) hz = 1'b1;
        end
`ifndef DECODE_REGFILE_BYPASS_EN
        if (wb_reg_write && ((u1 && a1 != 0 && a1 == wb_rd) ||
                             (u2 && a2 != 0 && a2 == wb_rd))) hz = 1'b1;
`endif
        if (!reset || m_sq) hz = 1'b0;
        e.load = !hz;
        e.tk = reset && !m_sq && !hz && kind == 5 &&
               ((f3 == 3'd0) == (v1 == v2));
        bb = ($signed(instr_if_id) >>> 31) * 4096 + int'(instr_if_id[7]) * 2048 +
             int'(instr_if_id[30:25]) * 32 + int'(instr_if_id[11:8]) * 2;
        e.tgt = pc_if_id - 32'd4 + 32'(bb);
        e.nx = '0;
        if (kind != 0 && !hz && !m_sq) begin
            hi = $signed(instr_if_id) >>> 20;
            e.nx.pc  = pc_if_id;
            e.nx.d1  = v1;
            e.nx.d2  = v2;
            e.nx.rs1 = a1;
            e.nx.rs2 = a2;
            e.nx.f3  = f3;
            e.nx.f7  = instr_if_id[30];
            e.nx.rw  = kind <= 3;
            e.nx.rd  = (kind <= 3) ? rd : 5'd0;
            e.nx.mr  = kind == 3;
            e.nx.m2r = kind == 3;
            e.nx.mw  = kind == 4;
            e.nx.as  = kind >= 2 && kind <= 4;
            e.nx.op  = (kind <= 2) ? 2'd2 : (kind == 5) ? 2'd1 : 2'd0;
            if (kind == 2 || kind == 3) e.nx.imm = 32'(hi);
            if (kind == 4) e.nx.imm = 32'((hi >>> 5) * 32 + int'(rd));
            if (kind == 5) e.nx.imm = 32'(bb);
        end
        return e;
    endfunction

    // Model state advance
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_ex <= '0;
            m_sq <= 1'b0;
            for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
        end else begin
            upd_e = model_eval();
            if (wb_reg_write && wb_rd != 5'd0) mregs[wb_rd] <= wb_data;
            m_ex <= upd_e.nx;
            m_sq <= upd_e.tk;
        end
    end

    // Every-cycle compare against the model
    always @(negedge clock) begin
        if (run) begin
            cmp_e = model_eval();
            chk("load_pc", 32'(load_pc), 32'(cmp_e.load));
            chk("load_if_id", 32'(load_if_id_register), 32'(cmp_e.load));
            chk("mux_sel", 32'(mux_sel), 32'(cmp_e.tk));
            chk("pc_branch_value", pc_branch_value, cmp_e.tgt);
            chk("id_ex_pc", id_ex_pc, m_ex.pc);
            chk("id_ex_rs1_data", id_ex_rs1_data, m_ex.d1);
            chk("id_ex_rs2_data", id_ex_rs2_data, m_ex.d2);
            chk("id_ex_imm", id_ex_imm, m_ex.imm);
            chk("id_ex_rs1", 32'(id_ex_rs1), 32'(m_ex.rs1));
            chk("id_ex_rs2", 32'(id_ex_rs2), 32'(m_ex.rs2));
            chk("id_ex_rd", 32'(id_ex_rd), 32'(m_ex.rd));
            chk("id_ex_funct3", 32'(id_ex_funct3), 32'(m_ex.f3));
            chk("id_ex_funct7b5", 32'(id_ex_funct7b5), 32'(m_ex.f7));
            chk("id_ex_reg_write", 32'(id_ex_reg_write), 32'(m_ex.rw));
            chk("id_ex_mem_read", 32'(id_ex_mem_read), 32'(m_ex.mr));
            chk("id_ex_mem_write", 32'(id_ex_mem_write), 32'(m_ex.mw));
            chk("id_ex_mem_to_reg", 32'(id_ex_mem_to_reg), 32'(m_ex.m2r));
            chk("id_ex_alu_src", 32'(id_ex_alu_src), 32'(m_ex.as));
            chk("id_ex_alu_op", 32'(id_ex_alu_op), 32'(m_ex.op));
        end
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7,
        input logic [4:0] b, input logic [4:0] a,
        input logic [2:0] f3, input logic [4:0] d);
        return {f7, b, a, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im,
        input logic [4:0] a, input logic [2:0] f3,
        input logic [4:0] d, input logic [6:0] op);
        return {im, a, f3, d, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] im,
        input logic [4:0] b, input logic [4:0] a);
        return {im[11:5], b, a, 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] im,
        input logic [4:0] b, input logic [4:0] a, input logic [2:0] f3);
        return {im[12], im[10:5], b, a, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    task automatic cyc(input logic [31:0] p, input logic [31:0] ins,
        input logic ww, input logic [4:0] wr, input logic [31:0] wd,
        input logic mw, input logic [4:0] mr);
        @(posedge clock);
        #1;
        pc_if_id      = p;
        instr_if_id   = ins;
        wb_reg_write  = ww;
        wb_rd         = wr;
        wb_data       = wd;
        mem_reg_write = mw;
        mem_rd        = mr;
    endtask

    logic [31:0] nop;
    logic [31:0] add7;
    logic [31:0] beq_m8;
    logic [31:0] addi12;

    initial begin
        nop = 32'd0;
        pc_if_id = 0; instr_if_id = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0;
        mem_reg_write = 0; mem_rd = 0;
        run = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst load_pc", 32'(load_pc), 32'd1);
        chk("rst mux_sel", 32'(mux_sel), 32'd0);
        chk("rst id_ex_reg_write", 32'(id_ex_reg_write), 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;

        cyc(32'h04, enc_i(12'hFFD, 5'd0, 3'd0, 5'd5, 7'h13), 0, 0, 0, 0, 0);
        cyc(32'h08, nop, 1, 5'd1, 32'd9, 0, 0);
        @(negedge clock);
        chk("addi imm", id_ex_imm, 32'hFFFFFFFD);
        chk("addi rd", 32'(id_ex_rd), 32'd5);
        chk("addi alu_src", 32'(id_ex_alu_src), 32'd1);
        chk("addi reg_write", 32'(id_ex_reg_write), 32'd1);
        cyc(32'h0C, nop, 1, 5'd2, 32'd9, 0, 0);

        add7 = enc_r(7'd0, 5'd1, 5'd6, 3'd0, 5'd7);
        cyc(32'h10, enc_i(12'd0, 5'd1, 3'b010, 5'd6, 7'h03), 0, 0, 0, 0, 0);
        cyc(32'h14, add7, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("lu load_pc", 32'(load_pc), 32'd0);
        chk("lu load_if_id", 32'(load_if_id_register), 32'd0);
        cyc(32'h14, add7, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("lu bubble rd", 32'(id_ex_rd), 32'd0);
        chk("lu release", 32'(load_pc), 32'd1);

        cyc(32'h24, enc_b(13'd16, 5'd2, 5'd1, 3'd0), 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("add issued rd", 32'(id_ex_rd), 32'd7);
        chk("beq mux_sel", 32'(mux_sel), 32'd1);
        chk("beq target", pc_branch_value, 32'h30);
        cyc(32'h28, enc_i(12'd1, 5'd0, 3'd0, 5'd8, 7'h13), 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("squash mux_sel", 32'(mux_sel), 32'd0);
        chk("beq alu_op", 32'(id_ex_alu_op), 32'd1);
        cyc(32'h30, nop, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("squashed reg_write", 32'(id_ex_reg_write), 32'd0);

        cyc(32'h34, enc_b(13'd8, 5'd2, 5'd1, 3'd1), 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("bne not taken", 32'(mux_sel), 32'd0);
        beq_m8 = enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0);
        cyc(32'h38, beq_m8, 0, 0, 0, 1, 5'd2);
        @(negedge clock);
        chk("br stall load_pc", 32'(load_pc), 32'd0);
        chk("br stall mux_sel", 32'(mux_sel), 32'd0);
        cyc(32'h38, beq_m8, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("beq back mux_sel", 32'(mux_sel), 32'd1);
        chk("beq back target", pc_branch_value, 32'h2C);
        cyc(32'h3C, enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd9), 0, 0, 0, 0, 0);

        cyc(32'h40, enc_r(7'd0, 5'd0, 5'd3, 3'd0, 5'd9), 1, 5'd3, 32'hABCD, 0, 0);
        @(negedge clock);
`ifdef DECODE_REGFILE_BYPASS_EN
        chk("byp no stall", 32'(load_pc), 32'd1);
`else
        chk("wb stall", 32'(load_pc), 32'd0);
        cyc(32'h40, enc_r(7'd0, 5'd0, 5'd3, 3'd0, 5'd9), 0, 0, 0, 0, 0);
`endif
        cyc(32'h44, nop, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("x3 read", id_ex_rs1_data, 32'hABCD);

        cyc(32'h48, nop, 1, 5'd0, 32'h55, 0, 0);
        cyc(32'h4C, enc_s(12'hFEC, 5'd2, 5'd0), 0, 0, 0, 0, 0);
        cyc(32'h50, {20'h12345, 5'd1, 7'b0110111}, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("sw imm", id_ex_imm, 32'hFFFFFFEC);
        chk("sw mem_write", 32'(id_ex_mem_write), 32'd1);
        chk("x0 reads 0", id_ex_rs1_data, 32'd0);
        chk("sw rs2_data", id_ex_rs2_data, 32'd9);
        cyc(32'h54, enc_b(13'd8, 5'd2, 5'd1, 3'b100), 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("bad op bubble", id_ex_pc, 32'd0);
        cyc(32'h58, nop, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("blt bubble mux", 32'(mux_sel), 32'd0);
        chk("blt bubble pc", id_ex_pc, 32'd0);

        cyc(32'h5C, enc_r(7'b0100000, 5'd2, 5'd1, 3'd0, 5'd11), 0, 0, 0, 0, 0);
        cyc(32'h60, nop, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("sub funct7b5", 32'(id_ex_funct7b5), 32'd1);
        chk("sub rd", 32'(id_ex_rd), 32'd11);

        addi12 = enc_i(12'd5, 5'd0, 3'd0, 5'd12, 7'h13);
        cyc(32'h64, enc_b(13'd8, 5'd0, 5'd0, 3'd0), 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("beq x0 taken", 32'(mux_sel), 32'd1);
        cyc(32'h68, addi12, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        @(negedge clock);
        chk("rst sq reg_write", 32'(id_ex_reg_write), 32'd0);
        chk("rst sq pc", id_ex_pc, 32'd0);
        chk("rst sq load_pc", 32'(load_pc), 32'd1);
        @(posedge clock);
        #1 reset = 1'b1;
        cyc(32'h6C, nop, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("post rst rd", 32'(id_ex_rd), 32'd12);
        chk("post rst imm", id_ex_imm, 32'd5);

        repeat (2) @(posedge clock);
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32-bit data and 5-bit register indices.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; clears all state immediately when 0.
REQ-004 pc_if_id  in  32  IF/ID pc field, holding the next-PC value (fetched address + 4).
REQ-005 instr_if_id  in  32  IF/ID instruction word.
REQ-006 wb_reg_write, wb_rd, wb_data  in  1/5/32  write-back port into the register file.
REQ-007 mem_reg_write, mem_rd  in  1/5  EX/MEM destination, used for branch hazard detection.
REQ-008 load_pc, load_if_id_register, mux_sel  out  1 each  fetch-stage control.
REQ-009 pc_branch_value  out  32  branch target.
REQ-010 id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm  out  32 each  ID/EX data fields.
REQ-011 id_ex_rs1, id_ex_rs2, id_ex_rd  out  5 each; id_ex_funct3  out  3; id_ex_funct7b5  out  1.
REQ-012 id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src  out  1 each; id_ex_alu_op  out  2.

Function
REQ-013 Decode SHALL support opcodes 0110011 (R), 0010011 (I-ALU), 0000011 (LW), 0100011 (SW), and 1100011 with funct3 000/001 (BEQ/BNE); any other opcode SHALL decode as a bubble (all control bits 0).
REQ-014 Immediates SHALL be sign-extended I, S, or B format by opcode; the B immediate SHALL have bit 0 = 0.
REQ-015 The register file SHALL be 32x32, with reads combinational, writes on clock when wb_reg_write=1, and writes to x0 ignored; x0 SHALL always read 0.
REQ-016 The ID/EX register SHALL capture decoded fields each cycle (latency 1); a bubble SHALL zero all control bits and id_ex_rd.
REQ-017 Load-use stall: when id_ex_mem_read=1, id_ex_rd!=0, and id_ex_rd equals a used rs of the current instruction, then load_pc=0, load_if_id_register=0, and a bubble is written to ID/EX.
REQ-018 Branch stall: when the current instruction is a branch and a nonzero rs matches id_ex_rd (with id_ex_reg_write=1) or mem_rd (with mem_reg_write=1), the block SHALL stall as in REQ-017.
REQ-019 The branch SHALL be evaluated only when not stalled and not squashed; BEQ is taken when rs1==rs2, BNE when rs1!=rs2.
REQ-020 pc_branch_value SHALL equal pc_if_id - 4 + imm_b (mod 2^32); mux_sel=1 only in a taken cycle, otherwise 0.
REQ-021 A taken branch SHALL set squash_q; in the next cycle the IF/ID instruction SHALL be discarded as a bubble, no stall or branch evaluation SHALL occur, and squash_q SHALL clear.
REQ-022 With no stall, load_pc and load_if_id_register SHALL both be 1.
REQ-023 Priority: squash > stall > branch evaluation.

Reset
REQ-024 While reset=0, all ID/EX outputs, squash_q, and every register-file entry SHALL be 0; mux_sel=0; load_pc and load_if_id_register SHALL be 1.
REQ-025 Reset asserted mid-stall or mid-squash SHALL abandon that state with no residual bubble after release.

Configuration
REQ-026 Macro DECODE_REGFILE_BYPASS_EN defined: a read of the register being written in the same cycle SHALL return wb_data.
REQ-027 Macro undefined: reads SHALL return the old value, and any used nonzero rs matching wb_rd with wb_reg_write=1 SHALL cause a one-cycle stall per REQ-017.

Structure
REQ-028 Package decode_pkg SHALL hold the opcode constants, the alu_op encodings (00 add, 01 sub/branch, 10 funct-decoded), and the immediate-format enum.
REQ-029 The register file SHALL be a sub-module named register_file; decode, hazard, and ID/EX logic SHALL reside in decode_stage.

Verification
REQ-030 Decode: addi x5,x0,-3 -> next cycle id_ex_imm=0xFFFFFFFD, id_ex_rd=5, id_ex_alu_src=1, id_ex_reg_write=1.
REQ-031 Load-use: lw x6 followed by add x7,x6,x1 -> one cycle with load_pc=0, load_if_id_register=0, and a bubble in ID/EX; the add is issued the following cycle.
REQ-032 Taken branch: x1=x2=9, beq x1,x2,+16 at pc_if_id=0x24 -> mux_sel=1, pc_branch_value=0x30; the next instruction is squashed.
REQ-033 Bypass: wb_rd=3, wb_data=0xABCD with add reading x3 in the same cycle -> id_ex_rs1_data=0xABCD with the macro defined; without it, a one-cycle stall followed by 0xABCD.
REQ-034 Reset: reset=0 during a squash -> all outputs zero and squash_q=0; after release, the first valid instruction issues normally.
